// File: rtl/ram_dump_pkg.sv
// ram_dump_tx shared types.
// FSM state encoding and the default frame header byte.
package ram_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_LAT,
    ST_BYTE,
    ST_CSUM,
    ST_FIN
  } state_t;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

endpackage

// File: rtl/ram_dump_tx_sender.sv
// tx_byte_sender: one-byte handshake towards avr_interface.
// Strobes only when tx_busy_i is low, then holds off for one guard cycle.
module tx_byte_sender (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] byte_i,
  input  logic       req_i,
  input  logic       tx_busy_i,
  output logic       accepted_o,
  output logic [7:0] tx_byte_o,
  output logic       new_tx_data_o
);

  logic       r_guard;
  logic [7:0] r_last;
  logic       w_fire;

  // tx_busy_i lags the strobe by a cycle, so it is masked by the guard
  assign w_fire = req_i && !r_guard && !tx_busy_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_guard <= 1'b0;
      r_last  <= 8'h00;
    end else begin
      r_guard <= w_fire;
      if (w_fire) r_last <= byte_i;
    end
  end

  assign accepted_o    = w_fire;
  assign new_tx_data_o = w_fire;
  assign tx_byte_o     = w_fire ? byte_i : r_last;

endmodule

// File: rtl/ram_dump_tx.sv
// ram_dump_tx: streams a block_ram word range out as a serial frame.
// Frame: header, words MSB byte first, XOR checksum of the data bytes.
module ram_dump_tx
  import ram_dump_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         DATA_W      = 16,
  parameter logic [7:0] HEADER_BYTE = HEADER_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] address_o,
  input  logic [DATA_W-1:0] data_i,
  output logic [7:0]        tx_byte_o,
  output logic              new_tx_data_o,
  input  logic              tx_busy_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BPW  = DATA_W / 8;
  localparam int BC_W = $clog2(BPW + 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [ADDR_W:0]     r_wcnt;
  logic [BC_W-1:0]     r_bcnt;
  logic [DATA_W-1:0]   r_word;
  logic [7:0]          r_csum;
  logic                w_req;
  logic [7:0]          w_byte;
  logic                w_acc;
  logic                w_last_byte;
  logic                w_last_word;
  logic [7:0]          w_top;

  assign w_top       = r_word[DATA_W-1 -: 8];
  assign w_last_byte = (r_bcnt == BC_W'(1));
  assign w_last_word = (r_wcnt == (ADDR_W+1)'(1));

  tx_byte_sender u_sender (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .byte_i        (w_byte),
    .req_i         (w_req),
    .tx_busy_i     (tx_busy_i),
    .accepted_o    (w_acc),
    .tx_byte_o     (tx_byte_o),
    .new_tx_data_o (new_tx_data_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_byte = 8'h00;
    unique case (r_state)
      ST_IDLE: if (start_i) w_next = ST_HDR;
      ST_HDR: begin
        w_req  = 1'b1;
        w_byte = HEADER_BYTE;
        if (w_acc) w_next = ST_RD;
      end
      ST_RD:  w_next = ST_LAT;
      ST_LAT: w_next = ST_BYTE;
      ST_BYTE: begin
        w_req  = 1'b1;
        w_byte = w_top;
        if (w_acc && w_last_byte)
          w_next = w_last_word ? ST_CSUM : ST_RD;
      end
      ST_CSUM: begin
        w_req  = 1'b1;
        w_byte = r_csum;
        if (w_acc) w_next = ST_FIN;
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr   <= '0;
      r_addr_q <= '0;
      r_wcnt   <= '0;
      r_bcnt   <= '0;
      r_word   <= '0;
      r_csum   <= 8'h00;
    end else begin
      if (r_state == ST_IDLE && start_i) begin
        r_addr <= start_addr_i;
        r_csum <= 8'h00;
        // zero length means the whole address space
        if (len_i == '0) r_wcnt <= {1'b1, {ADDR_W{1'b0}}};
        else             r_wcnt <= {1'b0, len_i};
      end
      if (r_state == ST_RD) r_addr_q <= r_addr;
      if (r_state == ST_LAT) begin
        r_word <= data_i;
        r_bcnt <= BC_W'(BPW);
      end
      if (r_state == ST_BYTE && w_acc) begin
        r_csum <= r_csum ^ w_top;
        r_word <= r_word << 8;
        r_bcnt <= r_bcnt - 1'b1;
        if (w_last_byte) begin
          r_wcnt <= r_wcnt - 1'b1;
          if (!w_last_word) r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  assign address_o = (r_state == ST_RD) ? r_addr : r_addr_q;
  assign busy_o    = (r_state != ST_IDLE);
  assign done_o    = (r_state == ST_FIN);

endmodule

// File: tb/tb_ram_dump_tx.sv
// Testbench for ram_dump_tx with a RAM model and an avr_interface busy model.
// Expected frames come from a byte-level reference of the frame format.
module tb_ram_dump_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [7:0]  start_addr = 8'h00;
  logic [7:0]  len = 8'h00;
  logic [7:0]  address;
  logic [15:0] data = 16'h0000;
  logic [7:0]  tx_byte;
  logic        new_tx;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ram_dump_tx dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .start_addr_i  (start_addr),
    .len_i         (len),
    .address_o     (address),
    .data_i        (data),
    .tx_byte_o     (tx_byte),
    .new_tx_data_o (new_tx),
    .tx_busy_i     (tx_busy),
    .busy_o        (busy),
    .done_o        (done)
  );

  logic [15:0] mem [256];
  always @(posedge clk) data <= mem[address];

  int checks = 0;
  int failures = 0;
  logic [7:0] rxq [$];
  logic [7:0] expq [$];
  int done_cnt = 0;
  int consec_err = 0;
  int busy_err = 0;
  bit prev_strobe = 0;
  bit strobe_seen = 0;
  bit busy_en = 0;
  bit pend = 0;
  int bcnt = 0;
  int hold = 20;

  always @(negedge clk) begin
    if (new_tx === 1'b1) begin
      rxq.push_back(tx_byte);
      if (prev_strobe) consec_err++;
      if (tx_busy) busy_err++;
    end
    prev_strobe = (new_tx === 1'b1);
    strobe_seen = (new_tx === 1'b1);
    if (done === 1'b1) done_cnt++;
  end

  // avr_interface: busy rises one cycle after the strobe, holds `hold` cycles
  always @(posedge clk) begin
    #1;
    if (pend) begin
      pend = 0;
      if (busy_en) begin
        tx_busy = 1'b1;
        bcnt = hold;
      end
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) tx_busy = 1'b0;
    end
    if (strobe_seen) pend = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_add(input logic [7:0] a, input logic [7:0] l);
    int words;
    logic [7:0] cs;
    logic [15:0] w;
    words = (l == 8'h00) ? 256 : int'(l);
    cs = 8'h00;
    expq.push_back(8'hA5);
    for (int i = 0; i < words; i++) begin
      w = mem[(int'(a) + i) % 256];
      expq.push_back(w[15:8]);
      expq.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    expq.push_back(cs);
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = a;
    len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 6000) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, done_cnt >= target, 1);
  endtask

  task automatic compare(input string tag);
    int m;
    check({tag, "_nbytes"}, rxq.size(), expq.size());
    m = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_b%0d", tag, i), rxq[i], expq[i]);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] a,
                           input logic [7:0] l);
    int d0;
    rxq.delete();
    expq.delete();
    model_add(a, l);
    d0 = done_cnt;
    pulse_start(a, l);
    wait_done(tag, d0 + 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt, d0 + 1);
    check({tag, "_busy_after"}, busy, 1'b0);
    compare(tag);
  endtask

  initial begin
    logic [7:0] t1 [6];
    int n;
    int d0;
    t1 = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_new_tx", new_tx, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", address, 8'h00);
    rst_n = 1'b1;

    // 1: basic two-word frame
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'hABCD;
    run_frame("t1", 8'h10, 8'h02);
    for (int i = 0; i < 6; i++)
      if (i < rxq.size()) check($sformatf("t1_const%0d", i), rxq[i], t1[i]);

    // 2: same frame with tx_busy_i held 20 cycles after each strobe
    busy_en = 1;
    hold = 20;
    run_frame("t2", 8'h10, 8'h02);
    check("t2_strobes", rxq.size(), 6);
    busy_en = 0;
    repeat (25) @(posedge clk);

    // 3: address wrap
    mem[8'hFF] = 16'h00FF;
    mem[8'h00] = 16'hFF00;
    run_frame("t3", 8'hFF, 8'h02);
    if (rxq.size() == 6) check("t3_csum", rxq[5], 8'h00);
    else check("t3_size", rxq.size(), 6);

    // 4: len 0 covers the full address space
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    run_frame("t4", 8'h37, 8'h00);
    if (rxq.size() >= 514) check("t4_last", {rxq[511], rxq[512]}, 16'h0036);
    else check("t4_size", rxq.size(), 514);
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    // 5: start ignored mid-frame and during done, accepted right after
    rxq.delete();
    expq.delete();
    model_add(8'h20, 8'h03);
    model_add(8'h70, 8'h02);
    d0 = done_cnt;
    pulse_start(8'h20, 8'h03);
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = 8'h50;
    len = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 6000);
    check("t5_done_found", done, 1'b1);
    start = 1'b1;
    start_addr = 8'h60;
    len = 8'h01;
    @(posedge clk); #1;
    start_addr = 8'h70;
    len = 8'h02;
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_busy_new", busy, 1'b1);
    wait_done("t5", d0 + 2);
    repeat (3) @(posedge clk);
    #1;
    check("t5_done_twice", done_cnt, d0 + 2);
    compare("t5");

    // 6: reset in the middle of a word
    rxq.delete();
    pulse_start(8'h40, 8'h02);
    n = 0;
    while (rxq.size() < 2 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("t6_pre_bytes", rxq.size(), 2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_new_tx", new_tx, 1'b0);
    check("t6_tx_byte", tx_byte, 8'h00);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_addr", address, 8'h00);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t6_no_strobe", rxq.size(), 2);
    run_frame("t6", 8'h40, 8'h02);

    // randomized frames, with and without the busy model
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) mem[$urandom_range(0, 255)] = 16'($urandom);
      busy_en = bit'($urandom_range(0, 1));
      hold = $urandom_range(1, 20);
      run_frame($sformatf("r%0d", k), 8'($urandom), 8'($urandom_range(1, 8)));
      busy_en = 0;
      repeat (25) @(posedge clk);
    end

    check("consec_strobes", consec_err, 0);
    check("strobe_while_busy", busy_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dump_tx.md
Name: ram_dump_tx

Overview:
Streams a range of 16-bit words from block_ram out through the avr_interface serial TX port.
- Sits downstream of block_ram's read port and upstream of the avr_interface TX user interface.
- Host-side readback of results without a command-processor round-trip per byte.
- Frame format: header byte, then each word MSB byte first, then an XOR checksum byte.

Parameters:
ADDR_W, 8, RAM address width; address arithmetic wraps modulo 2^ADDR_W.
DATA_W, 16, RAM word width; must be a multiple of 8; bytes per word = DATA_W/8.
HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
clk_i  in  1  system clock (50 MHz)
rst_n_i  in  1  reset, asynchronous assert, active-low
start_i  in  1  single-cycle request; sampled only in IDLE
start_addr_i  in  ADDR_W  first word address, captured with start_i
len_i  in  ADDR_W  word count, captured with start_i; 0 means 2^ADDR_W words
address_o  out  ADDR_W  RAM read address
data_i  in  DATA_W  RAM read data, valid 1 cycle after address_o
tx_byte_o  out  8  byte to avr_interface tx_data
new_tx_data_o  out  1  single-cycle strobe to avr_interface new_tx_data
tx_busy_i  in  1  avr_interface tx_busy
busy_o  out  1  high from accepted start_i until done_o
done_o  out  1  single-cycle pulse after the checksum byte is strobed

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; address_o=0, tx_byte_o=0, new_tx_data_o=0, busy_o=0, done_o=0, checksum=0, counters=0.
- Reset mid-frame aborts the frame immediately. No partial checksum is emitted.
- IDLE: start_i=1 captures start_addr_i and len_i, sets busy_o, clears checksum, goes to HDR. start_i while busy_o=1 is ignored.
- TX handshake, used by every send:
  - A byte is strobed only when tx_busy_i=0 and the 1-cycle guard is clear.
  - new_tx_data_o and tx_byte_o are driven in the same cycle.
  - The guard cycle follows every strobe, because avr_interface raises tx_busy_i one cycle late. tx_busy_i is ignored during the guard cycle.
  - new_tx_data_o is never high on two consecutive cycles.
- States:
  - HDR: strobe HEADER_BYTE, then go to RD.
  - RD: drive address_o = current address for 1 cycle, then go to LAT.
  - LAT: capture data_i into the word shift register (1-cycle RAM latency), then go to BYTE.
  - BYTE: strobe word[DATA_W-1 -: 8] and XOR it into checksum. Shift the word left by 8 and decrement the byte counter. After the last byte of the word:
    - if words remain: address+1 (wraps, e.g. 8'hFF -> 8'h00), go to RD;
    - otherwise go to CSUM.
  - CSUM: strobe the checksum byte, then go to FIN.
  - FIN: pulse done_o, clear busy_o, return to IDLE. A new start_i is accepted in the cycle after done_o.
- The header byte is excluded from the checksum.
- address_o holds its last value outside RD. RAM write access is arbitrated outside this block, gated by busy_o.
- Frame latency with tx_busy_i tied low: 2 cycles per strobed byte, plus 2 cycles per word read.
- Total bytes per frame = 2 + words*(DATA_W/8).
- len_i=0 sends 2^ADDR_W words, starting at start_addr_i and wrapping.

Decomposition:
- Shared package (ram_dump_pkg): state encoding constants (IDLE, HDR, RD, LAT, BYTE, CSUM, FIN) and the default HEADER_BYTE.
- One sub-module, tx_byte_sender: owns the tx_busy_i/guard handshake.
  - Inputs: byte + send request. Outputs: accepted pulse, tx_byte_o, new_tx_data_o.
  - Unit-tested standalone; the main FSM waits on its accepted pulse.

Test Plan:
1. RAM[0x10]=16'h1234, RAM[0x11]=16'hABCD; start addr 0x10, len 2; tx_busy_i=0 -> TX bytes A5,12,34,AB,CD,checksum 0x40; done_o once; busy_o low after.
2. Same frame; model avr_interface so tx_busy_i rises 1 cycle after each strobe and holds for 20 cycles -> identical byte sequence, exactly 6 strobes, none while tx_busy_i=1 outside guard.
3. Start addr 0xFF, len 2, RAM[0xFF]=16'h00FF, RAM[0x00]=16'hFF00 -> reads 0xFF then 0x00; bytes A5,00,FF,FF,00,checksum 0x00.
4. len 0, RAM[i]=i -> 514 bytes total; last data word from address start-1; checksum matches model.
5. start_i pulsed again mid-frame and in the cycle done_o is high -> both ignored; start_i one cycle after done_o -> new frame begins with A5.
6. rst_n_i low mid-word -> outputs zero asynchronously, no further strobes; after release, a start_i frame is correct from its header.
